// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss handler between the I/D-cache miss outputs and a
// pipelined multi-cycle main memory. It arbitrates one miss (D-cache first),
// issues WORDS word reads for the missing block, streams the returned words
// into the owning cache's data array, then writes the tag for one cycle.
module cache_fill_fsm #(
   parameter int ADDR_W = 16,
   parameter int WORDS  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dcache_miss,
   input  logic [ADDR_W-1:0] dcache_miss_addr,
   input  logic              icache_miss,
   input  logic [ADDR_W-1:0] icache_miss_addr,
   input  logic              mem_data_valid,
   input  logic [ADDR_W-1:0] mem_data,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              fill_we,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [ADDR_W-1:0] fill_data,
   output logic              tag_we,
   output logic              arbiter_select,
   output logic              busy,
   output logic              fill_done
);

   // Counters must reach WORDS itself (saturated issue side).
   localparam int CNT_W = $clog2(WORDS + 1);
   // Byte-offset bits within a block of WORDS 16-bit words.
   localparam int OFF_W = $clog2(WORDS * 2);
   localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      TAG  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  issue_cnt;
   logic [CNT_W-1:0]  recv_cnt;
   logic [ADDR_W-1:0] base;
   logic              accept;

   // Offset bits of the miss addresses are dropped when the block base is formed.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{dcache_miss_addr[OFF_W-1:0], icache_miss_addr[OFF_W-1:0]};

   // Byte address of word cnt inside the block; wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] blk,
                                                   input logic [CNT_W-1:0]  cnt);
      return blk + (ADDR_W'(cnt) << 1);
   endfunction

   // Block-aligned base address of a faulting byte address.
   function automatic logic [ADDR_W-1:0] block_of(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   endfunction

   // A returned word is taken only while filling and before the block is complete.
   assign accept = (state == FILL) && mem_data_valid && (recv_cnt < WORDS_C);

   // Request, fill-write and status decode from current state and counters.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      mem_en    = 1'b0;
      mem_addr  = '0;
      fill_we   = 1'b0;
      fill_addr = '0;
      fill_data = '0;
      busy      = (state != IDLE);
      if (state == FILL && issue_cnt < WORDS_C) begin
         mem_en   = 1'b1;
         mem_addr = word_addr(base, issue_cnt);
      end
      if (accept) begin
         fill_we   = 1'b1;
         fill_addr = word_addr(base, recv_cnt);
         fill_data = mem_data;
      end else if (state == TAG) begin
         fill_addr = base;
      end
   end

   // Fill sequencer: arbitration, counters and the registered one-cycle pulses.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all state so every update sees pre-edge values.
      if (rst) begin
         state          <= IDLE;
         issue_cnt      <= '0;
         recv_cnt       <= '0;
         base           <= '0;
         arbiter_select <= 1'b1;
         tag_we         <= 1'b0;
         fill_done      <= 1'b0;
      end else begin
         tag_we    <= 1'b0;
         fill_done <= 1'b0;
         case (state)
            IDLE: begin
               issue_cnt <= '0;
               recv_cnt  <= '0;
               if (dcache_miss) begin
                  base           <= block_of(dcache_miss_addr);
                  arbiter_select <= 1'b1;
                  state          <= FILL;
               end else if (icache_miss) begin
                  base           <= block_of(icache_miss_addr);
                  arbiter_select <= 1'b0;
                  state          <= FILL;
               end
            end
            FILL: begin
               if (issue_cnt < WORDS_C) begin
                  issue_cnt <= issue_cnt + 1'b1;
               end
               if (accept) begin
                  recv_cnt <= recv_cnt + 1'b1;
                  if (recv_cnt == LAST_C) begin
                     state  <= TAG;
                     tag_we <= 1'b1;
                  end
               end
            end
            TAG: begin
               state     <= DONE;
               fill_done <= 1'b1;
            end
            DONE: begin
               state     <= IDLE;
               issue_cnt <= '0;
               recv_cnt  <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed bench for cache_fill_fsm. A cycle table covers
// the single D-cache fill; a small in-order memory model drives the
// multi-cycle scenarios (arbitration, gapped returns, reset abort, wrap).
module tb_cache_fill_fsm;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        dcache_miss;
   logic [15:0] dcache_miss_addr;
   logic        icache_miss;
   logic [15:0] icache_miss_addr;
   logic        mem_data_valid;
   logic [15:0] mem_data;
   logic        mem_en;
   logic [15:0] mem_addr;
   logic        fill_we;
   logic [15:0] fill_addr;
   logic [15:0] fill_data;
   logic        tag_we;
   logic        arbiter_select;
   logic        busy;
   logic        fill_done;

   always #5 clk = ~clk;

   cache_fill_fsm #(.ADDR_W(16), .WORDS(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .dcache_miss      (dcache_miss),
      .dcache_miss_addr (dcache_miss_addr),
      .icache_miss      (icache_miss),
      .icache_miss_addr (icache_miss_addr),
      .mem_data_valid   (mem_data_valid),
      .mem_data         (mem_data),
      .mem_en           (mem_en),
      .mem_addr         (mem_addr),
      .fill_we          (fill_we),
      .fill_addr        (fill_addr),
      .fill_data        (fill_data),
      .tag_we           (tag_we),
      .arbiter_select   (arbiter_select),
      .busy             (busy),
      .fill_done        (fill_done)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One row per cycle of the single D-cache fill (miss seen at edge 0).
   typedef struct {
      bit          dmiss;
      logic [15:0] daddr;
      bit          valid;
      logic [15:0] data;
      bit          e_mem_en;
      logic [15:0] e_mem_addr;
      bit          e_we;
      logic [15:0] e_faddr;
      logic [15:0] e_fdata;
      bit          e_tag;
      bit          e_done;
      bit          e_busy;
      bit          e_arb;
   } vec_t;

   vec_t vt[16];

   // In-order memory model and per-scenario statistics.
   typedef struct {
      logic [15:0] addr;
      int          due;
   } req_t;

   req_t        pend[$];
   int          cyc;
   bit          gap_mode;
   bit          spurious;
   bit          prev_mem_en;
   int          n_we, n_tag, n_done, order_err;
   logic [15:0] req_log[$];
   logic [15:0] tag_addr_log[$];
   bit          tag_arb_log[$];
   int          we_at_tag[$];
   int          done_cyc[$];
   int          start_cyc[$];

   task automatic clear_stats();
      pend.delete();
      req_log.delete();
      tag_addr_log.delete();
      tag_arb_log.delete();
      we_at_tag.delete();
      done_cyc.delete();
      start_cyc.delete();
      cyc = 0; n_we = 0; n_tag = 0; n_done = 0; order_err = 0;
      prev_mem_en = 1'b0;
   endtask

   // Drive memory response for this cycle, observe outputs, advance one clock.
   task automatic step();
      req_t head;
      bit   give;
      give = 1'b0;
      head = '{addr: 16'h0, due: 0};
      if (pend.size() > 0 && pend[0].due <= cyc)
         give = gap_mode ? ((cyc % 3) == 0) : 1'b1;
      if (give) begin
         head           = pend.pop_front();
         mem_data_valid = 1'b1;
         mem_data       = head.addr ^ 16'h5A5A;
      end else if (spurious) begin
         mem_data_valid = 1'b1;
         mem_data       = 16'hDEAD;
      end else begin
         mem_data_valid = 1'b0;
         mem_data       = 16'h0;
      end
      #1;
      if (mem_en) begin
         pend.push_back('{addr: mem_addr, due: cyc + LAT});
         req_log.push_back(mem_addr);
         if (!prev_mem_en) start_cyc.push_back(cyc);
      end
      prev_mem_en = mem_en;
      if (spurious) check("spurious_valid_no_fill_we", fill_we, 1'b0);
      if (fill_we) begin
         n_we++;
         if (!give || fill_addr !== head.addr || fill_data !== (head.addr ^ 16'h5A5A))
            order_err++;
      end
      if (tag_we) begin
         n_tag++;
         tag_addr_log.push_back(fill_addr);
         tag_arb_log.push_back(arbiter_select);
         we_at_tag.push_back(n_we);
      end
      if (fill_done) begin
         n_done++;
         done_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Run until the expected number of fill_done pulses or a cycle budget expires.
   task automatic run_until_done(input int want, input int budget);
      for (int k = 0; k < budget && n_done < want; k++) step();
   endtask

   initial begin
      // Build the single-fill table: request cycles 1-8, returns 5-12, tag 13, done 14.
      for (int c = 0; c < 16; c++) begin
         vt[c].dmiss      = (c == 0);
         vt[c].daddr      = (c == 0) ? 16'h1234 : 16'h0;
         vt[c].e_mem_en   = (c >= 1 && c <= 8);
         vt[c].e_mem_addr = vt[c].e_mem_en ? 16'(16'h1230 + 2 * (c - 1)) : 16'h0;
         vt[c].valid      = (c >= 5 && c <= 12);
         vt[c].data       = vt[c].valid ? 16'(16'hC000 + c) : 16'h0;
         vt[c].e_we       = vt[c].valid;
         vt[c].e_faddr    = vt[c].valid ? 16'(16'h1230 + 2 * (c - 5)) :
                            (c == 13) ? 16'h1230 : 16'h0;
         vt[c].e_fdata    = vt[c].data;
         vt[c].e_tag      = (c == 13);
         vt[c].e_done     = (c == 14);
         vt[c].e_busy     = (c >= 1 && c <= 14);
         vt[c].e_arb      = 1'b1;
      end

      gap_mode = 1'b0;
      spurious = 1'b0;
      clear_stats();

      // Reset held 4 cycles with both misses pending.
      rst              = 1'b1;
      dcache_miss      = 1'b1;
      dcache_miss_addr = 16'h1111;
      icache_miss      = 1'b1;
      icache_miss_addr = 16'h2222;
      mem_data_valid   = 1'b0;
      mem_data         = 16'h0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("reset_busy", busy, 1'b0);
         check("reset_mem_en", mem_en, 1'b0);
         check("reset_arb", arbiter_select, 1'b1);
         check("reset_tag_we", tag_we, 1'b0);
      end
      rst         = 1'b0;
      icache_miss = 1'b0;

      // Single D-cache fill from the table.
      for (int c = 0; c < 16; c++) begin
         dcache_miss      = vt[c].dmiss;
         dcache_miss_addr = vt[c].daddr;
         mem_data_valid   = vt[c].valid;
         mem_data         = vt[c].data;
         #1;
         check($sformatf("t%0d_mem_en", c), mem_en, vt[c].e_mem_en);
         check($sformatf("t%0d_mem_addr", c), mem_addr, vt[c].e_mem_addr);
         check($sformatf("t%0d_fill_we", c), fill_we, vt[c].e_we);
         check($sformatf("t%0d_fill_addr", c), fill_addr, vt[c].e_faddr);
         check($sformatf("t%0d_fill_data", c), fill_data, vt[c].e_fdata);
         check($sformatf("t%0d_tag_we", c), tag_we, vt[c].e_tag);
         check($sformatf("t%0d_fill_done", c), fill_done, vt[c].e_done);
         check($sformatf("t%0d_busy", c), busy, vt[c].e_busy);
         check($sformatf("t%0d_arb", c), arbiter_select, vt[c].e_arb);
         @(posedge clk);
         #1;
      end
      mem_data_valid = 1'b0;

      // Simultaneous misses: D block first, one IDLE cycle, then I block.
      clear_stats();
      dcache_miss      = 1'b1;
      dcache_miss_addr = 16'h0040;
      icache_miss      = 1'b1;
      icache_miss_addr = 16'h2008;
      step();
      dcache_miss = 1'b0;
      for (int k = 0; k < 80 && n_done < 2; k++) begin
         step();
         if (start_cyc.size() >= 2) icache_miss = 1'b0;
      end
      icache_miss = 1'b0;
      repeat (3) step();
      check("dual_fill_we_count", n_we, 16);
      check("dual_tag_count", n_tag, 2);
      check("dual_fill_count", start_cyc.size(), 2);
      check("dual_first_base", tag_addr_log[0], 16'h0040);
      check("dual_first_arb", tag_arb_log[0], 1'b1);
      check("dual_second_base", tag_addr_log[1], 16'h2000);
      check("dual_second_arb", tag_arb_log[1], 1'b0);
      check("dual_first_start", start_cyc[0], 1);
      check("dual_idle_gap", start_cyc[1] - done_cyc[0], 2);
      check("dual_order", order_err, 0);

      // Gapped memory returns, spurious valid in IDLE and in DONE.
      clear_stats();
      spurious = 1'b1;
      step();
      spurious = 1'b0;
      gap_mode         = 1'b1;
      dcache_miss      = 1'b1;
      dcache_miss_addr = 16'h3456;
      step();
      dcache_miss = 1'b0;
      for (int k = 0; k < 200 && n_done == 0; k++) begin
         step();
         spurious = (n_tag == 1 && n_done == 0);
      end
      spurious = 1'b0;
      gap_mode = 1'b0;
      repeat (2) step();
      check("gap_fill_we_count", n_we, 8);
      check("gap_we_before_tag", we_at_tag[0], 8);
      check("gap_tag_count", n_tag, 1);
      check("gap_done_count", n_done, 1);
      check("gap_order", order_err, 0);
      check("gap_req_count", req_log.size(), 8);
      check("gap_first_req", req_log[0], 16'h3450);

      // Reset after the 3rd returned word aborts the fill.
      clear_stats();
      dcache_miss      = 1'b1;
      dcache_miss_addr = 16'h5000;
      step();
      dcache_miss = 1'b0;
      for (int k = 0; k < 40 && n_we < 3; k++) step();
      check("abort_three_words", n_we, 3);
      rst            = 1'b1;
      mem_data_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_tag_we", tag_we, 1'b0);
      check("abort_arb", arbiter_select, 1'b1);
      clear_stats();
      repeat (6) step();
      check("abort_no_tag", n_tag, 0);
      check("abort_no_done", n_done, 0);
      check("abort_no_we", n_we, 0);
      icache_miss      = 1'b1;
      icache_miss_addr = 16'h6010;
      step();
      icache_miss = 1'b0;
      run_until_done(1, 60);
      check("refill_we_count", n_we, 8);
      check("refill_first_req", req_log[0], 16'h6010);
      check("refill_tag_addr", tag_addr_log[0], 16'h6010);
      check("refill_arb", tag_arb_log[0], 1'b0);
      check("refill_order", order_err, 0);

      // Top-of-memory block: no address past 0xFFFE.
      step();
      clear_stats();
      icache_miss      = 1'b1;
      icache_miss_addr = 16'hFFFA;
      step();
      icache_miss = 1'b0;
      run_until_done(1, 60);
      step();
      check("wrap_req_count", req_log.size(), 8);
      for (int i = 0; i < 8; i++)
         check($sformatf("wrap_req%0d", i), req_log[i], 16'(16'hFFF0 + 2 * i));
      check("wrap_fill_we_count", n_we, 8);
      check("wrap_tag_addr", tag_addr_log[0], 16'hFFF0);
      check("wrap_order", order_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss handler that sits directly downstream of the I-cache and D-cache miss outputs and upstream of the multi-cycle main memory. It arbitrates between an I-cache miss and a D-cache miss, then fetches the missing 16-byte block as 8 pipelined 16-bit word reads. It streams the returned words into the selected cache's data array and finishes with a one-cycle tag write. It drives the cache's arbiter_select so that only one cache owns the fill path at a time.

Parameters:
ADDR_W, 16, address and data width in bits
WORDS, 8, 16-bit words per cache block (block = 16 bytes, offset = addr[3:0])

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
dcache_miss  in  1  D-cache miss_detected
dcache_miss_addr  in  16  D-cache faulting byte address
icache_miss  in  1  I-cache miss_detected
icache_miss_addr  in  16  I-cache faulting byte address
mem_data_valid  in  1  memory read data valid this cycle
mem_data  in  16  memory read data
mem_en  out  1  memory read request this cycle
mem_addr  out  16  memory read byte address
fill_we  out  1  write fill_data into the selected cache data array
fill_addr  out  16  cache byte address for fill_data
fill_data  out  16  word to write (equals mem_data)
tag_we  out  1  one-cycle tag/valid write for the filled block
arbiter_select  out  1  1 = D-cache owns fill path, 0 = I-cache
busy  out  1  high whenever state != IDLE (pipeline stall)
fill_done  out  1  one-cycle pulse in the cycle after tag_we

Behaviour:
- States: IDLE, FILL, TAG, DONE. Reset, or rst high at any edge: IDLE, issue_cnt = recv_cnt = 0, base = 0, arbiter_select = 1, all other outputs 0. A reset during FILL aborts the fill; no tag_we is issued.
- IDLE: if dcache_miss, latch base = {dcache_miss_addr[15:4],4'b0} and set arbiter_select = 1. Else if icache_miss, latch the I-cache address and set arbiter_select = 0. Either case moves to FILL at the next edge. D-cache wins when both misses are high.
- arbiter_select holds its value from IDLE exit until the next arbitration. It does not change in FILL, TAG or DONE.
- FILL issue side: mem_en = 1 while issue_cnt < WORDS, with mem_addr = base + 2*issue_cnt. issue_cnt increments each cycle and saturates at WORDS. This gives exactly 8 consecutive request cycles starting in the first FILL cycle. mem_addr = 0 when mem_en = 0.
- FILL receive side: when mem_data_valid is high, fill_we = 1, fill_addr = base + 2*recv_cnt, fill_data = mem_data, and recv_cnt increments. Issue and receive may overlap in the same cycle. Words return in request order.
- mem_data_valid is ignored in IDLE, TAG and DONE, and ignored once recv_cnt == WORDS.
- FILL -> TAG at the edge where the 8th valid word is accepted.
- TAG: tag_we = 1, fill_addr = base, for one cycle; then DONE.
- DONE: fill_done = 1 for one cycle; then IDLE, with counters cleared.
- A miss still pending in IDLE starts a new arbitration; a back-to-back fill therefore has one IDLE cycle between fills.
- Miss inputs and miss addresses are ignored outside IDLE. A miss that drops mid-fill does not abort the fill.
- busy is combinational from state, so it is 0 only in IDLE.
- Address arithmetic is modulo 2^16. A block at 0xFFF0 issues 0xFFF0..0xFFFE with no wrap into the next block.
- With a 4-cycle memory and a miss seen at edge 0: mem_en is high in cycles 1-8, fill_we in cycles 5-12, tag_we in cycle 13, fill_done in cycle 14, and IDLE resumes in cycle 15.

Test Plan:
- Reset: hold rst 4 cycles with both misses high -> state IDLE, busy = 0, mem_en = 0, arbiter_select = 1 throughout reset.
- Single D-cache miss, addr 0x1234, 4-cycle memory model -> mem_addr 0x1230,0x1232,...,0x123E in cycles 1-8. fill_we with matching fill_addr/data in cycles 5-12, tag_we in cycle 13, fill_done in cycle 14, arbiter_select = 1.
- Simultaneous misses, D 0x0040 and I 0x2008 -> D block 0x0040 filled first with arbiter_select = 1. One IDLE cycle follows, then the I block 0x2000 fill with arbiter_select = 0. Exactly 16 fill_we and 2 tag_we in total.
- Irregular memory: mem_data_valid gapped (pattern 1,0,0,1,...) -> exactly 8 fill_we, fill_addr strictly increasing by 2, TAG entered only after the 8th word. Spurious valid pulses in IDLE and DONE produce no fill_we.
- Reset mid-fill: assert rst after the 3rd valid word -> next cycle IDLE, no tag_we, no fill_done. A subsequent miss performs a full 8-word fill from recv_cnt 0.
- Wrap boundary: I-cache miss at 0xFFFA -> requests 0xFFF0..0xFFFE, no address beyond 0xFFFE.
